// File: rtl/rom_load_pkg.sv
// Shared FSM encodings, counter widths and the download address check for the ROM load arbiter.
package rom_load_pkg;

   typedef enum logic {ARB, RD_WAIT} port_state_t;
   typedef enum logic [1:0] {RUN, LOAD, FLUSH, SETTLE} seq_state_t;

   localparam int unsigned ROMAD_W   = 25;
   localparam int unsigned LAT_CW    = 3;
   localparam int unsigned SETTLE_CW = 8;

   // Full-width compare so high ROMAD bits cannot alias into the memory window.
   function automatic logic addr_in_range(input logic [ROMAD_W-1:0] ad, input int unsigned lim);
      return ad < ROMAD_W'(lim);
   endfunction

endpackage

// File: rtl/rom_load_seq.sv
// Core hold sequencer: keeps HOLD high through a download and for RELEASE_CYC cycles afterwards.
module rom_load_seq
   import rom_load_pkg::*;
#(
   parameter int unsigned RELEASE_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic dlact_rise,
   input  logic dlact_fall,
   input  logic buf_empty,
   input  logic port_idle,
   output logic hold
);

   seq_state_t           state;
   logic [SETTLE_CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SETTLE;
         cnt   <= SETTLE_CW'(RELEASE_CYC);
         hold  <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (dlact_rise) begin
                  state <= LOAD;
                  hold  <= 1'b1;
               end
            end
            LOAD: begin
               if (dlact_fall) state <= FLUSH;
            end
            FLUSH: begin
               if (dlact_rise) begin
                  state <= LOAD;
               end else if (buf_empty && port_idle) begin
                  state <= SETTLE;
                  cnt   <= SETTLE_CW'(RELEASE_CYC);
               end
            end
            SETTLE: begin
               // A new download abandons the release countdown.
               if (dlact_rise) begin
                  state <= LOAD;
               end else if (cnt <= SETTLE_CW'(1)) begin
                  state <= RUN;
                  cnt   <= '0;
                  hold  <= 1'b0;
               end else begin
                  cnt <= cnt - SETTLE_CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/rom_load_arbiter.sv
// Shares one byte-wide memory port between the ioctl download stream and core reads,
// and holds the core in reset while a download is in progress.
module rom_load_arbiter
   import rom_load_pkg::*;
#(
   parameter int unsigned AW          = 16,
   parameter int unsigned DL_SIZE     = 'hE000,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned RELEASE_CYC = 64
) (
   input  logic               MCLK,
   input  logic               RESET,
   input  logic               DLACT,
   input  logic               ROMEN,
   input  logic [ROMAD_W-1:0] ROMAD,
   input  logic [7:0]         ROMDT,
   input  logic               RDREQ,
   input  logic [AW-1:0]      RDAD,
   output logic [7:0]         RDDT,
   output logic               RDACK,
   output logic [AW-1:0]      MEM_AD,
   output logic [7:0]         MEM_WD,
   output logic               MEM_WE,
   output logic               MEM_RE,
   input  logic [7:0]         MEM_RD,
   output logic               HOLD,
   output logic               OOR,
   output logic               OVF
);

   port_state_t       state;
   logic [LAT_CW-1:0] lat_cnt;
   logic              dlact_q;
   logic              buf_full;
   logic [AW-1:0]     buf_ad;
   logic [7:0]        buf_wd;

   logic          dlact_rise, dlact_fall;
   logic          in_range, accept, buf_full_n;
   logic          start_rd, rd_last, issue_wr;
   logic [AW-1:0] wr_ad;
   logic [7:0]    wr_wd;

   assign dlact_rise = DLACT & ~dlact_q;
   assign dlact_fall = ~DLACT & dlact_q;
   assign in_range   = addr_in_range(ROMAD, DL_SIZE);
   assign accept     = ROMEN & in_range & ~buf_full;
   // The entry stays full through the cycle its MEM_WE is on the port.
   assign buf_full_n = (buf_full & ~MEM_WE) | accept;

   assign start_rd = (state == ARB) & ~buf_full & RDREQ & ~DLACT & ~RDACK;
   assign rd_last  = (state == RD_WAIT) && (lat_cnt == '0);
   // Writes are scheduled one edge ahead so MEM_WE lands in the cycle the buffer is full in ARB.
   assign issue_wr = buf_full_n & (((state == ARB) & ~start_rd) | rd_last);
   assign wr_ad    = buf_full ? buf_ad : ROMAD[AW-1:0];
   assign wr_wd    = buf_full ? buf_wd : ROMDT;

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state    <= ARB;
         lat_cnt  <= '0;
         dlact_q  <= 1'b0;
         buf_full <= 1'b0;
         buf_ad   <= '0;
         buf_wd   <= '0;
         RDDT     <= '0;
         RDACK    <= 1'b0;
         MEM_AD   <= '0;
         MEM_WD   <= '0;
         MEM_WE   <= 1'b0;
         MEM_RE   <= 1'b0;
         OOR      <= 1'b0;
         OVF      <= 1'b0;
      end else begin
         dlact_q  <= DLACT;
         buf_full <= buf_full_n;
         if (accept) begin
            buf_ad <= ROMAD[AW-1:0];
            buf_wd <= ROMDT;
         end

         MEM_WE <= issue_wr;
         MEM_RE <= start_rd;
         RDACK  <= rd_last;
         RDDT   <= rd_last ? MEM_RD : 8'h00;
         if (issue_wr) begin
            MEM_AD <= wr_ad;
            MEM_WD <= wr_wd;
         end else if (start_rd) begin
            MEM_AD <= RDAD;
         end

         case (state)
            ARB: begin
               if (start_rd) begin
                  state   <= RD_WAIT;
                  lat_cnt <= LAT_CW'(RD_LAT - 1);
               end
            end
            RD_WAIT: begin
               if (lat_cnt == '0) state <= ARB;
               else               lat_cnt <= lat_cnt - LAT_CW'(1);
            end
         endcase

         OOR <= (OOR & ~dlact_rise) | (ROMEN & ~in_range);
         OVF <= (OVF & ~dlact_rise) | (ROMEN & buf_full);
      end
   end

   rom_load_seq #(
      .RELEASE_CYC(RELEASE_CYC)
   ) u_seq (
      .clk        (MCLK),
      .rst        (RESET),
      .dlact_rise (dlact_rise),
      .dlact_fall (dlact_fall),
      .buf_empty  (~buf_full),
      .port_idle  (state == ARB),
      .hold       (HOLD)
   );

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Scoreboard bench for rom_load_arbiter: expected writes/reads are queued at stimulus time
// and popped when MEM_WE / RDACK appear on the sampled outputs.
module tb_rom_load_arbiter;

   localparam int unsigned AW          = 16;
   localparam int unsigned RD_LAT      = 2;
   localparam int unsigned RELEASE_CYC = 64;

   logic          MCLK  = 1'b0;
   logic          RESET = 1'b1;
   logic          DLACT = 1'b0;
   logic          ROMEN = 1'b0;
   logic [24:0]   ROMAD = '0;
   logic [7:0]    ROMDT = '0;
   logic          RDREQ = 1'b0;
   logic [AW-1:0] RDAD  = '0;
   logic [7:0]    MEM_RD = '0;
   logic [7:0]    RDDT;
   logic          RDACK;
   logic [AW-1:0] MEM_AD;
   logic [7:0]    MEM_WD;
   logic          MEM_WE;
   logic          MEM_RE;
   logic          HOLD;
   logic          OOR;
   logic          OVF;

   typedef struct {
      logic [AW-1:0] ad;
      logic [7:0]    wd;
      int unsigned   due;
   } wr_exp_t;

   typedef struct {
      logic [7:0]  d;
      int unsigned due;
   } rd_exp_t;

   wr_exp_t     wr_q[$];
   rd_exp_t     rd_q[$];
   int unsigned cyc = 0;
   int unsigned re_seen = 0;
   int unsigned we_seen = 0;
   int unsigned compared = 0;
   int unsigned mismatched = 0;

   rom_load_arbiter #(
      .AW(AW), .DL_SIZE('hE000), .RD_LAT(RD_LAT), .RELEASE_CYC(RELEASE_CYC)
   ) dut (
      .MCLK(MCLK), .RESET(RESET), .DLACT(DLACT), .ROMEN(ROMEN), .ROMAD(ROMAD),
      .ROMDT(ROMDT), .RDREQ(RDREQ), .RDAD(RDAD), .RDDT(RDDT), .RDACK(RDACK),
      .MEM_AD(MEM_AD), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
      .MEM_RD(MEM_RD), .HOLD(HOLD), .OOR(OOR), .OVF(OVF)
   );

   always #5 MCLK = ~MCLK;

   task automatic push_wr(input logic [AW-1:0] ad, input logic [7:0] wd, input int unsigned due);
      wr_exp_t w;
      w.ad = ad; w.wd = wd; w.due = due;
      wr_q.push_back(w);
   endtask

   task automatic push_rd(input logic [7:0] d, input int unsigned due);
      rd_exp_t r;
      r.d = d; r.due = due;
      rd_q.push_back(r);
   endtask

   // One clock: sample on the falling edge and retire any write/read completions.
   task automatic tick();
      wr_exp_t w;
      rd_exp_t r;
      @(negedge MCLK);
      cyc++;
      if (MEM_RE === 1'b1) re_seen++;
      if (MEM_WE === 1'b1) begin
         we_seen++;
         compared++;
         if (wr_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write cyc=%0d got ad=%h wd=%h, want no write", cyc, MEM_AD, MEM_WD);
         end else begin
            w = wr_q.pop_front();
            if (MEM_AD !== w.ad || MEM_WD !== w.wd || cyc != w.due) begin
               mismatched++;
               $display("FAIL write got ad=%h wd=%h cyc=%0d, want ad=%h wd=%h cyc=%0d",
                        MEM_AD, MEM_WD, cyc, w.ad, w.wd, w.due);
            end
         end
      end
      if (RDACK === 1'b1) begin
         compared++;
         if (rd_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_rdack cyc=%0d got rddt=%h, want no ack", cyc, RDDT);
         end else begin
            r = rd_q.pop_front();
            if (RDDT !== r.d || cyc != r.due) begin
               mismatched++;
               $display("FAIL read got rddt=%h cyc=%0d, want rddt=%h cyc=%0d", RDDT, cyc, r.d, r.due);
            end
         end
      end
   endtask

   task automatic strobe(input logic [24:0] ad, input logic [7:0] dt);
      ROMEN = 1'b1; ROMAD = ad; ROMDT = dt;
   endtask

   task automatic test_reset();
      int n;
      RESET = 1'b1;
      tick(); tick();
      compared++;
      if (HOLD !== 1'b1) begin mismatched++; $display("FAIL reset_hold got %b, want 1", HOLD); end
      compared++;
      if ({MEM_WE, MEM_RE, RDACK, OOR, OVF} !== 5'b0 || MEM_AD !== '0 || MEM_WD !== '0 || RDDT !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs got we=%b re=%b ack=%b oor=%b ovf=%b ad=%h wd=%h dt=%h, want all 0",
                  MEM_WE, MEM_RE, RDACK, OOR, OVF, MEM_AD, MEM_WD, RDDT);
      end
      RESET = 1'b0;
      n = 0;
      do begin tick(); n++; end while (HOLD === 1'b1 && n < 300);
      compared++;
      if (n != RELEASE_CYC) begin mismatched++; $display("FAIL reset_release got %0d cycles, want %0d", n, RELEASE_CYC); end
      compared++;
      if (we_seen + re_seen != 0) begin mismatched++; $display("FAIL reset_strobes got %0d, want 0", we_seen + re_seen); end
   endtask

   task automatic test_download();
      int unsigned re0;
      DLACT = 1'b1;
      tick(); tick();
      compared++;
      if (HOLD !== 1'b1) begin mismatched++; $display("FAIL download_hold got %b, want 1", HOLD); end
      // Core read requests must be ignored while the download is active.
      RDREQ = 1'b1; RDAD = 16'h0777;
      re0 = re_seen;
      for (int i = 0; i < 3; i++) begin
         strobe(25'(i), 8'((i + 1) * 'h11));
         push_wr(AW'(i), 8'((i + 1) * 'h11), cyc + 1);
         tick();
         ROMEN = 1'b0;
         tick(); tick(); tick();
      end
      RDREQ = 1'b0;
      compared++;
      if (wr_q.size() != 0) begin mismatched++; $display("FAIL download_writes got %0d pending, want 0", wr_q.size()); end
      compared++;
      if (re_seen != re0 || HOLD !== 1'b1) begin
         mismatched++;
         $display("FAIL download_no_read got re=%0d hold=%b, want re=%0d hold=1", re_seen - re0, HOLD, 0);
      end
   endtask

   task automatic test_overflow();
      strobe(25'h5, 8'h55);
      push_wr(16'h0005, 8'h55, cyc + 1);
      tick();
      strobe(25'h6, 8'h66);
      tick();
      ROMEN = 1'b0;
      tick(); tick();
      compared++;
      if (OVF !== 1'b1 || OOR !== 1'b0) begin mismatched++; $display("FAIL overflow_flag got ovf=%b oor=%b, want 1 0", OVF, OOR); end
      DLACT = 1'b0;
      tick(); tick(); tick();
      DLACT = 1'b1;
      tick(); tick();
      compared++;
      if (OVF !== 1'b0) begin mismatched++; $display("FAIL overflow_clear got %b, want 0", OVF); end
   endtask

   task automatic test_out_of_range();
      strobe(25'hE000, 8'hAA);
      tick();
      ROMEN = 1'b0;
      tick(); tick();
      compared++;
      if (OOR !== 1'b1 || OVF !== 1'b0) begin mismatched++; $display("FAIL oor_flag got oor=%b ovf=%b, want 1 0", OOR, OVF); end
      strobe(25'hDFFF, 8'h9C);
      push_wr(16'hDFFF, 8'h9C, cyc + 1);
      tick();
      ROMEN = 1'b0;
      tick();
      // High ROMAD bit with zero low bits must not alias onto address 0.
      strobe(25'h100_0000, 8'hC3);
      tick();
      ROMEN = 1'b0;
      tick(); tick();
      compared++;
      if (wr_q.size() != 0 || OOR !== 1'b1) begin
         mismatched++;
         $display("FAIL oor_boundary got pending=%0d oor=%b, want 0 1", wr_q.size(), OOR);
      end
   endtask

   task automatic test_settle_restart();
      int n;
      int unsigned low_seen;
      DLACT = 1'b0;
      low_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (HOLD !== 1'b1) low_seen++;
      end
      DLACT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (HOLD !== 1'b1) low_seen++;
      end
      compared++;
      if (low_seen != 0) begin mismatched++; $display("FAIL settle_hold got %0d low cycles, want 0", low_seen); end
      compared++;
      if (OOR !== 1'b0) begin mismatched++; $display("FAIL oor_clear got %b, want 0", OOR); end
      DLACT = 1'b0;
      n = 0;
      do begin tick(); n++; end while (HOLD === 1'b1 && n < 300);
      // One edge to see the fall and one FLUSH cycle precede the full countdown.
      compared++;
      if (n != RELEASE_CYC + 2) begin mismatched++; $display("FAIL settle_restart got %0d cycles, want %0d", n, RELEASE_CYC + 2); end
   endtask

   task automatic test_read();
      logic [AW-1:0] ad;
      logic [7:0]    d;
      int unsigned   re0;
      for (int k = 0; k < 2; k++) begin
         ad = (k == 0) ? 16'h1234 : 16'hBEEF;
         d  = (k == 0) ? 8'hA5 : 8'h3C;
         MEM_RD = d; RDAD = ad; RDREQ = 1'b1;
         re0 = re_seen;
         push_rd(d, cyc + RD_LAT + 1);
         tick();
         compared++;
         if (MEM_RE !== 1'b1 || MEM_AD !== ad) begin
            mismatched++; $display("FAIL read_issue got re=%b ad=%h, want 1 %h", MEM_RE, MEM_AD, ad);
         end
         tick();
         compared++;
         if (MEM_RE !== 1'b0 || MEM_AD !== ad) begin
            mismatched++; $display("FAIL read_addr_hold got re=%b ad=%h, want 0 %h", MEM_RE, MEM_AD, ad);
         end
         tick();
         compared++;
         if (RDACK !== 1'b1) begin mismatched++; $display("FAIL read_ack got %b, want 1", RDACK); end
         tick();
         compared++;
         if (RDACK !== 1'b0) begin mismatched++; $display("FAIL read_ack_pulse got %b, want 0", RDACK); end
         RDREQ = 1'b0;
         tick();
         compared++;
         if (re_seen - re0 != 1) begin mismatched++; $display("FAIL read_single_re got %0d, want 1", re_seen - re0); end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned re0;
      MEM_RD = 8'h5E; RDAD = 16'h0100; RDREQ = 1'b1;
      re0 = re_seen;
      push_rd(8'h5E, cyc + RD_LAT + 1);
      tick();
      // Strobe lands while the read is in flight; written on the first ARB cycle.
      strobe(25'h40, 8'h77);
      push_wr(16'h0040, 8'h77, cyc + 2);
      tick();
      ROMEN = 1'b0;
      tick(); tick();
      RDREQ = 1'b0;
      tick(); tick();
      compared++;
      if (wr_q.size() != 0 || rd_q.size() != 0 || re_seen - re0 != 1) begin
         mismatched++;
         $display("FAIL back_to_back got wr=%0d rd=%0d re=%0d, want 0 0 1", wr_q.size(), rd_q.size(), re_seen - re0);
      end
   endtask

   task automatic test_reset_mid_read();
      strobe(25'hF000, 8'h01);
      tick();
      ROMEN = 1'b0;
      tick();
      compared++;
      if (OOR !== 1'b1) begin mismatched++; $display("FAIL oor_idle got %b, want 1", OOR); end
      RDAD = 16'h2000; MEM_RD = 8'hEE; RDREQ = 1'b1;
      tick(); tick();
      RESET = 1'b1;
      RDREQ = 1'b0;
      #1;
      compared++;
      if ({MEM_WE, MEM_RE, RDACK, OOR, OVF} !== 5'b0 || MEM_AD !== '0 || RDDT !== '0 || HOLD !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_mid_read got we=%b re=%b ack=%b oor=%b ovf=%b ad=%h dt=%h hold=%b, want 0s hold=1",
                  MEM_WE, MEM_RE, RDACK, OOR, OVF, MEM_AD, RDDT, HOLD);
      end
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      compared++;
      if (HOLD !== 1'b1 || RDACK !== 1'b0) begin
         mismatched++; $display("FAIL reset_mid_read_after got hold=%b ack=%b, want 1 0", HOLD, RDACK);
      end
   endtask

   initial begin
      test_reset();
      test_download();
      test_overflow();
      test_out_of_range();
      test_settle_restart();
      test_read();
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout at cyc=%0d, want completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
